pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that replaces the fixed-field, always-advancing stage registers between core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque control bundle and data bundle with a valid/ready handshake, supports back-pressure, flush, and bubble insertion, and optionally has a 2-entry skid buffer so that `in_ready` is a registered signal. One instance sits between each pair of pipeline stages.

---
 rtl/pipe_stage_reg.sv | 102 ++++++++++
 tb/tb_pipe_stage_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: opaque ctrl/data bundles with a valid/ready handshake,
// flush, zero-control bubbles and an optional 2-entry skid buffer.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned DATA_W = 192,
  parameter bit          SKID   = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  logic              r_main_v;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_v;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_occ;

  logic w_in_ready;
  logic w_acc;
  logic w_xfer;
  logic w_main_v_nxt;
  logic w_skid_v_nxt;
  logic w_main_ld_in;
  logic w_main_ld_skid;
  logic w_skid_ld;
  logic [1:0] w_occ_nxt;

  // With SKID=0 the skid entry can never load: an accept into a held main is
  // impossible because in_ready already requires main to be empty or draining.
  always_comb begin
    w_in_ready     = SKID ? !r_skid_v : (!r_main_v || out_ready);
    w_acc          = in_valid && w_in_ready;
    w_xfer         = r_main_v && out_ready;
    w_main_v_nxt   = r_main_v;
    w_skid_v_nxt   = r_skid_v;
    w_main_ld_in   = 1'b0;
    w_main_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    if (FLUSH) begin
      w_main_v_nxt = 1'b0;
      w_skid_v_nxt = 1'b0;
    end else if (r_skid_v && w_xfer) begin
      w_main_ld_skid = 1'b1;
      w_skid_v_nxt   = 1'b0;
    end else if (w_acc && (!r_main_v || w_xfer)) begin
      w_main_ld_in = 1'b1;
      w_main_v_nxt = 1'b1;
    end else if (w_acc) begin
      w_skid_ld    = 1'b1;
      w_skid_v_nxt = 1'b1;
    end else if (w_xfer) begin
      w_main_v_nxt = 1'b0;
    end
    w_occ_nxt = {1'b0, w_main_v_nxt} + {1'b0, w_skid_v_nxt};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_main_v    <= 1'b0;
      r_skid_v    <= 1'b0;
      r_occ       <= '0;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_main_v <= w_main_v_nxt;
      r_skid_v <= w_skid_v_nxt;
      r_occ    <= w_occ_nxt;
      if (w_main_ld_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_main_ld_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_skid_ld) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_main_v;
  assign out_ctrl  = r_main_v ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occ       = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table + hand sequences against the SKID=1 build, and a randomized
// single-entry model check against the SKID=0 build.
module tb_pipe_stage_reg;

  logic         CLK;
  logic         RST_N;

  logic         s1_flush, s1_iv, s1_ir, s1_ov, s1_or;
  logic [23:0]  s1_ic, s1_oc;
  logic [191:0] s1_id, s1_od;
  logic [1:0]   s1_occ;

  logic         s0_flush, s0_iv, s0_ir, s0_ov, s0_or;
  logic [23:0]  s0_ic, s0_oc;
  logic [191:0] s0_id, s0_od;
  logic [1:0]   s0_occ;

  int unsigned n_chk;
  int unsigned n_err;

  pipe_stage_reg #(.CTRL_W(24), .DATA_W(192), .SKID(1'b1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(s1_flush),
    .in_valid(s1_iv), .in_ready(s1_ir), .in_ctrl(s1_ic), .in_data(s1_id),
    .out_valid(s1_ov), .out_ready(s1_or), .out_ctrl(s1_oc), .out_data(s1_od),
    .occ(s1_occ)
  );

  pipe_stage_reg #(.CTRL_W(24), .DATA_W(192), .SKID(1'b0)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(s0_flush),
    .in_valid(s0_iv), .in_ready(s0_ir), .in_ctrl(s0_ic), .in_data(s0_id),
    .out_valid(s0_ov), .out_ready(s0_or), .out_ctrl(s0_oc), .out_data(s0_od),
    .occ(s0_occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign s1_id = {8{s1_ic}};
  assign s0_id = {8{s0_ic}};

  typedef struct {
    logic        iv;
    logic [23:0] ic;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [23:0] ec;
    logic [1:0]  eocc;
    logic        eir;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(logic iv, logic [23:0] ic, logic o, logic f,
                              logic ev, logic [23:0] ec, logic [1:0] eo, logic eir);
    vec_t v;
    v.iv = iv; v.ic = ic; v.ordy = o; v.fl = f;
    v.ev = ev; v.ec = ec; v.eocc = eo; v.eir = eir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_s1(input string tag, input logic ev, input logic [23:0] ec,
                        input logic [1:0] eo, input logic eir);
    chk({tag, ".out_valid"}, 192'(s1_ov), 192'(ev));
    chk({tag, ".out_ctrl"},  192'(s1_oc), 192'(ev ? ec : 24'h0));
    chk({tag, ".occ"},       192'(s1_occ), 192'(eo));
    chk({tag, ".in_ready"},  192'(s1_ir), 192'(eir));
    if (ev) chk({tag, ".out_data"}, s1_od, {8{ec}});
  endtask

  initial begin
    logic        m_v;
    logic [23:0] m_c;
    logic [23:0] seq;
    logic        exp_ir;

    n_chk = 0; n_err = 0;
    RST_N = 1'b0;
    s1_flush = 1'b0; s1_iv = 1'b0; s1_or = 1'b0; s1_ic = '0;
    s0_flush = 1'b0; s0_iv = 1'b0; s0_or = 1'b0; s0_ic = '0;

    // stream, bubble, back-pressure, flush with full skid, flush discarding accept
    vt[0]  = mk(1, 24'h000001, 1, 0,  1, 24'h000001, 2'd1, 1);
    vt[1]  = mk(1, 24'h000002, 1, 0,  1, 24'h000002, 2'd1, 1);
    vt[2]  = mk(1, 24'h000003, 1, 0,  1, 24'h000003, 2'd1, 1);
    vt[3]  = mk(1, 24'h000004, 1, 0,  1, 24'h000004, 2'd1, 1);
    vt[4]  = mk(1, 24'h000005, 1, 0,  1, 24'h000005, 2'd1, 1);
    vt[5]  = mk(0, 24'h0000EE, 1, 0,  0, 24'h000000, 2'd0, 1);
    vt[6]  = mk(1, 24'h000006, 1, 0,  1, 24'h000006, 2'd1, 1);
    vt[7]  = mk(1, 24'h000007, 1, 0,  1, 24'h000007, 2'd1, 1);
    vt[8]  = mk(0, 24'h000000, 1, 0,  0, 24'h000000, 2'd0, 1);
    vt[9]  = mk(1, 24'h00000A, 0, 0,  1, 24'h00000A, 2'd1, 1);
    vt[10] = mk(1, 24'h00000B, 0, 0,  1, 24'h00000A, 2'd2, 0);
    vt[11] = mk(1, 24'h00000C, 0, 0,  1, 24'h00000A, 2'd2, 0);
    vt[12] = mk(1, 24'h00000C, 1, 0,  1, 24'h00000B, 2'd1, 1);
    vt[13] = mk(1, 24'h00000C, 1, 0,  1, 24'h00000C, 2'd1, 1);
    vt[14] = mk(0, 24'h000000, 1, 0,  0, 24'h000000, 2'd0, 1);
    vt[15] = mk(1, 24'h000011, 0, 0,  1, 24'h000011, 2'd1, 1);
    vt[16] = mk(1, 24'h000012, 0, 0,  1, 24'h000011, 2'd2, 0);
    vt[17] = mk(1, 24'h00000D, 0, 1,  0, 24'h000000, 2'd0, 1);
    vt[18] = mk(1, 24'h000013, 1, 0,  1, 24'h000013, 2'd1, 1);
    vt[19] = mk(1, 24'h000014, 1, 1,  0, 24'h000000, 2'd0, 1);
    vt[20] = mk(0, 24'h000000, 1, 0,  0, 24'h000000, 2'd0, 1);
    vt[21] = mk(1, 24'h000015, 1, 0,  1, 24'h000015, 2'd1, 1);
    vt[22] = mk(0, 24'h000000, 0, 0,  1, 24'h000015, 2'd1, 1);
    vt[23] = mk(0, 24'h000000, 1, 0,  0, 24'h000000, 2'd0, 1);

    repeat (2) @(posedge CLK);
    #1;
    chk_s1("reset", 1'b0, 24'h0, 2'd0, 1'b1);
    chk("reset.out_data", s1_od, '0);
    chk("reset.s0_in_ready", 192'(s0_ir), 192'(1'b1));

    @(negedge CLK) RST_N = 1'b1;

    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      s1_iv = vt[i].iv; s1_ic = vt[i].ic; s1_or = vt[i].ordy; s1_flush = vt[i].fl;
      @(posedge CLK);
      #1;
      chk_s1($sformatf("vec%0d", i), vt[i].ev, vt[i].ec, vt[i].eocc, vt[i].eir);
    end

    // asynchronous reset between edges while both entries are held
    @(negedge CLK); s1_iv = 1'b1; s1_ic = 24'h000031; s1_or = 1'b0; s1_flush = 1'b0;
    @(negedge CLK); s1_ic = 24'h000032;
    @(posedge CLK); #1;
    chk_s1("arst.full", 1'b1, 24'h000031, 2'd2, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    chk_s1("arst.cleared", 1'b0, 24'h0, 2'd0, 1'b1);
    chk("arst.out_data", s1_od, '0);
    @(negedge CLK); RST_N = 1'b1; s1_iv = 1'b0; s1_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk_s1($sformatf("arst.post%0d", i), 1'b0, 24'h0, 2'd0, 1'b1);
    end
    @(negedge CLK); s1_iv = 1'b1; s1_ic = 24'h000033;
    @(posedge CLK); #1;
    chk_s1("arst.new", 1'b1, 24'h000033, 2'd1, 1'b1);
    @(negedge CLK); s1_iv = 1'b0;
    @(posedge CLK); #1;
    chk_s1("arst.drain", 1'b0, 24'h0, 2'd0, 1'b1);

    // SKID=0 build against a one-entry model
    m_v = 1'b0; m_c = '0; seq = 24'h000100;
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      s0_iv    = 1'($urandom_range(0, 1));
      s0_or    = 1'($urandom_range(0, 1));
      s0_flush = ($urandom_range(0, 15) == 0);
      s0_ic    = seq;
      #1;
      exp_ir = !m_v || s0_or;
      chk("s0.in_ready", 192'(s0_ir), 192'(exp_ir));
      chk("s0.out_valid", 192'(s0_ov), 192'(m_v));
      chk("s0.out_ctrl", 192'(s0_oc), 192'(m_v ? m_c : 24'h0));
      chk("s0.occ", 192'(s0_occ), 192'({1'b0, m_v}));
      if (m_v) chk("s0.out_data", s0_od, {8{m_c}});
      if (s0_flush) begin
        m_v = 1'b0;
      end else if (s0_iv && exp_ir) begin
        m_v = 1'b1;
        m_c = seq;
        seq = seq + 24'd1;
      end else if (m_v && s0_or) begin
        m_v = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
